jpeg_bit_packer: RTL and testbench

JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

---
 rtl/jpeg_bit_packer.sv | 99 +++++++++
 tb/tb_jpeg_bit_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-coded bit packer: appends variable-length codes MSB-first into a
// left-aligned accumulator, emits bytes with 0xFF->0x00 stuffing, pads with 1s on flush.
module jpeg_bit_packer #(
    parameter int CODE_W = 32,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              flush_done
);
    localparam int AW = CODE_W + 8;
    localparam int CW = $clog2(AW + 1);

    typedef enum logic [1:0] {RUN, PAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stuff_q, stuff_d;

    logic [AW-1:0]   len_mask, code_ext, pad_mask;
    logic [CW-1:0]   sh, rnd;
    logic            pop;

    assign in_ready   = (cnt_q < CW'(8)) && !stuff_q && (state_q == RUN);
    assign out_valid  = stuff_q || (cnt_q >= CW'(8));
    assign out_data   = stuff_q ? 8'h00 : acc_q[AW-1 -: 8];
    assign flush_done = (state_q == DONE);
    assign pop        = out_valid && out_ready;

    // New code lands directly below the existing bits; sh >= 1 since cnt < 8.
    assign len_mask = (AW'(1) << in_len) - AW'(1);
    assign code_ext = AW'(in_code) & len_mask;
    assign sh       = CW'(AW) - cnt_q - CW'(in_len);

    // Ones from the current fill point down to the next byte boundary.
    assign rnd      = {cnt_q[CW-1:3] + (CW-3)'(1), 3'b000};
    assign pad_mask = ({AW{1'b1}} >> cnt_q) & ~({AW{1'b1}} >> rnd);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        stuff_d = stuff_q;

        if (pop) begin
            if (stuff_q) begin
                stuff_d = 1'b0;
            end else begin
                acc_d   = acc_q << 8;
                cnt_d   = cnt_q - CW'(8);
                stuff_d = (acc_q[AW-1 -: 8] == 8'hFF);
            end
        end

        case (state_q)
            RUN: begin
                if (in_valid && in_ready) begin
                    acc_d = acc_q | (code_ext << sh);
                    cnt_d = cnt_q + CW'(in_len);
                end
                if (flush && in_ready)
                    state_d = PAD;
            end
            PAD: begin
                if (cnt_q[2:0] != 3'd0 && !pop) begin
                    acc_d = acc_q | pad_mask;
                    cnt_d = rnd;
                end else if (cnt_q == '0 && !stuff_q) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            stuff_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
        end
    end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Bench for jpeg_bit_packer: directed scenarios plus random codes, checked against a
// bit-queue reference model that packs, pads and stuffs at the bitstream level.
module tb_jpeg_bit_packer;
    logic        clk = 0, n_rst = 0, in_valid = 0, flush = 0, out_ready = 1;
    logic [31:0] in_code = 0;
    logic [5:0]  in_len = 0;
    logic        in_ready, out_valid, flush_done;
    logic [7:0]  out_data;

    int errors = 0, checks = 0, done_cnt = 0, rdy_mode = 1;
    bit         bq[$];
    logic [7:0] eq[$];
    bit         flush_pend = 0, prev_stall = 0;
    logic [7:0] prev_data = 0;

    always #5 clk = ~clk;

    jpeg_bit_packer dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .flush_done(flush_done)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Reference: bitstream queue -> bytes, 1-padding on flush, 0x00 after every 0xFF.
    task automatic model_push(input logic [31:0] code, input int len, input bit fl);
        logic [7:0] b;
        for (int i = len - 1; i >= 0; i--) bq.push_back(code[i]);
        if (fl) while (bq.size() % 8 != 0) bq.push_back(1'b1);
        while (bq.size() >= 8) begin
            b = 0;
            for (int k = 0; k < 8; k++) b = {b[6:0], bq.pop_front()};
            eq.push_back(b);
            if (b == 8'hFF) eq.push_back(8'h00);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        out_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(3) != 0);
    end

    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            bq.delete(); eq.delete(); flush_pend = 0; prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                chk("byte_expected", eq.size() != 0, 1);
                if (eq.size() != 0) chk("byte", out_data, eq.pop_front());
            end
            if (flush_done) begin
                chk("done_pending", flush_pend, 1);
                chk("done_drained", eq.size(), 0);
                flush_pend = 0;
                done_cnt++;
            end
            if (in_valid && in_ready) model_push(in_code, int'(in_len), flush);
            else if (flush && in_ready) model_push(0, 0, 1);
            if (flush && in_ready) flush_pend = 1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] c, input int l, input bit fl);
        int n = 0;
        in_code = c; in_len = 6'(l); flush = fl; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((eq.size() != 0 || flush_pend || out_valid) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("drain_in_time", n < 2000, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_flush_done", flush_done, 0);
        @(posedge clk); #1; n_rst = 1;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_flush_done", flush_done, 0);
        @(posedge clk); #1;

        send(32'h5, 3, 0);
        send(32'h13, 5, 0);
        @(negedge clk);
        chk("b3_valid", out_valid, 1);
        chk("b3_data", out_data, 8'hB3);
        @(negedge clk);
        chk("b3_count0", out_valid, 0);
        drain();

        send(32'hFF, 8, 0);
        @(negedge clk);
        chk("ff_data", out_data, 8'hFF);
        chk("ff_in_ready", in_ready, 0);
        @(negedge clk);
        chk("stuff_data", out_data, 8'h00);
        chk("stuff_in_ready", in_ready, 0);
        @(negedge clk);
        chk("post_stuff_ready", in_ready, 1);
        drain();

        d0 = done_cnt;
        send(32'hA, 4, 1);
        @(negedge clk);
        @(negedge clk);
        chk("af_data", out_data, 8'hAF);
        drain();
        chk("af_one_done", done_cnt - d0, 1);
        d0 = done_cnt;
        send(32'h7F, 7, 1);
        drain();
        chk("7f_one_done", done_cnt - d0, 1);
        d0 = done_cnt;
        send(32'h0, 0, 1);
        drain();
        chk("empty_flush_done", done_cnt - d0, 1);

        rdy_mode = 0; out_ready = 0;
        send(32'h1234, 16, 0);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8'h12);
            chk("stall_in_ready", in_ready, 0);
        end
        rdy_mode = 1;
        drain();

        rdy_mode = 0; out_ready = 0;
        send(32'hABC, 12, 0);
        n_rst = 0;
        @(posedge clk); #1; n_rst = 1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 8'h00);
        rdy_mode = 1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        d0 = done_cnt;
        send(32'h0, 0, 1);
        drain();
        chk("midrst_count0_flush", done_cnt - d0, 1);

        rdy_mode = 2;
        for (int i = 0; i < 300; i++)
            send($urandom, $urandom_range(0, 32), $urandom_range(0, 9) == 0);
        send(32'h0, 0, 1);
        rdy_mode = 1;
        drain();
        chk("rand_model_empty", eq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
